// File: rtl/seven_seg_scan_ctrl_pkg.sv
// seven_seg_pkg: scan phase type and active-high hex glyph table shared by the scan controller
package seven_seg_pkg;
  typedef enum logic {PH_BLANK, PH_SHOW} scan_phase_t;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;
  localparam logic [6:0] GLYPHS [16] = '{GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
                                         GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F};
endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// seven_seg_scan_ctrl_if: display word/strobe/enable inputs and scan outputs of the controller
interface seven_seg_scan_ctrl_if #(parameter int N_DIGITS = 4);
  logic [4*N_DIGITS-1:0] value;
  logic                  load;
  logic [N_DIGITS-1:0]   digit_en;
  logic [6:0]            seg;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_done;
  logic                  pending;
  modport master (output value, load, digit_en, input seg, an, frame_done, pending);
  modport slave  (input value, load, digit_en, output seg, an, frame_done, pending);
endinterface

// File: rtl/seven_seg_scan_ctrl_deco.sv
// seven_segment_display_deco: hex nibble to active-high segments, s_a..s_g
module seven_segment_display_deco
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic       s_a,
  output logic       s_b,
  output logic       s_c,
  output logic       s_d,
  output logic       s_e,
  output logic       s_f,
  output logic       s_g
);
  assign {s_g, s_f, s_e, s_d, s_c, s_b, s_a} = GLYPHS[i_hex];
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: double-buffered N-digit multiplexed display scanner with per-slot blanking
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DIV          = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  seven_seg_scan_ctrl_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*N_DIGITS-1:0]   r_disp;
  logic [4*N_DIGITS-1:0]   r_pend;
  logic                    r_pend_valid;
  logic [6:0]              r_seg;
  logic [N_DIGITS-1:0]     r_an;
  logic                    r_frame_done;
  logic                    w_slot_end;
  logic                    w_frame_end;
  scan_phase_t             w_phase;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg;
  logic [N_DIGITS-1:0]     w_onehot;
  assign w_slot_end  = r_cnt == CNT_LAST;
  assign w_frame_end = w_slot_end && r_idx == IDX_LAST;
  assign w_phase     = (r_cnt < CNT_BLANK) ? PH_BLANK : PH_SHOW;
  assign w_nib       = r_disp[{r_idx, 2'b00} +: 4];
  assign w_onehot    = {{(N_DIGITS-1){1'b0}}, 1'b1} << r_idx;
  seven_segment_display_deco u_deco (
    .i_hex (w_nib),
    .s_a   (w_seg[0]),
    .s_b   (w_seg[1]),
    .s_c   (w_seg[2]),
    .s_d   (w_seg[3]),
    .s_e   (w_seg[4]),
    .s_f   (w_seg[5]),
    .s_g   (w_seg[6])
  );
  // slot counter and digit index walk; index wraps at the end of each frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      r_idx <= w_slot_end ? (w_frame_end ? '0 : r_idx + 1'b1) : r_idx;
    end
  // pending buffer takes every load; display word only swaps on a frame boundary so nothing tears
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_disp       <= '0;
    end else begin
      if (bus.load) r_pend <= bus.value;
      if (w_frame_end && (r_pend_valid || bus.load)) begin
        r_disp       <= bus.load ? bus.value : r_pend;
        r_pend_valid <= 1'b0;
      end else if (bus.load) r_pend_valid <= 1'b1;
    end
  // registered pin drive: digit enable only in the SHOW part of an enabled slot, segments follow the same index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_an         <= '0;
      r_seg        <= SEG_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= (w_phase == PH_SHOW && bus.digit_en[r_idx]) ? w_onehot : '0;
      r_seg        <= w_seg;
      r_frame_done <= w_frame_end;
    end
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.frame_done = r_frame_done;
  assign bus.pending    = r_pend_valid;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: random and directed stimulus checked against a cycle-count reference model
module tb_seven_seg_scan_ctrl;
  localparam int N = 4;
  localparam int DIV = 4;
  localparam int BL = 1;
  localparam int FRAME = N * DIV;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int k = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_pv = 1'b0;
  logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  always #5 clk = ~clk;
  seven_seg_scan_ctrl_if #(.N_DIGITS(N)) bus ();
  seven_seg_scan_ctrl #(.N_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(BL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask
  // one clock: model derives slot/digit from the cycle count since reset release
  task automatic step(input logic ld, input logic [15:0] val);
    int c, ix;
    logic fe;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    bus.load = ld;
    bus.value = val;
    @(posedge clk);
    c = k % DIV;
    ix = (k / DIV) % N;
    fe = (k % FRAME) == FRAME - 1;
    e_an = (c >= BL && bus.digit_en[ix]) ? 4'(1 << ix) : 4'h0;
    e_seg = glyph[m_disp[ix*4 +: 4]];
    if (fe && (m_pv || ld)) begin
      m_disp = ld ? val : m_pend;
      m_pv = 1'b0;
    end else if (ld) m_pv = 1'b1;
    if (ld) m_pend = val;
    k++;
    #1;
    chk("an", 32'(bus.an), 32'(e_an));
    chk("seg", 32'(bus.seg), 32'(e_seg));
    chk("frame_done", 32'(bus.frame_done), 32'(fe));
    chk("pending", 32'(bus.pending), 32'(m_pv));
    bus.load = 1'b0;
  endtask
  task automatic run_to(input int p);
    while (k % FRAME != p) step(1'b0, 16'h0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask
  initial begin
    bus.value = '0;
    bus.load = 1'b0;
    bus.digit_en = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", 32'(bus.an), 0);
    chk("rst_seg", 32'(bus.seg), 0);
    chk("rst_fd", 32'(bus.frame_done), 0);
    chk("rst_pending", 32'(bus.pending), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(32);
    run_to(5);
    step(1'b1, 16'h8F10);
    idle(32);
    run_to(3);
    step(1'b1, 16'h1111);
    run_to(9);
    step(1'b1, 16'h2222);
    idle(32);
    run_to(15);
    step(1'b1, 16'h0008);
    idle(20);
    bus.digit_en = 4'b0101;
    idle(32);
    bus.digit_en = 4'hF;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) bus.digit_en = 4'($urandom);
      step($urandom_range(0, 5) == 0, 16'($urandom));
    end
    bus.digit_en = 4'hF;
    run_to(0);
    step(1'b1, 16'h5A5A);
    run_to(10);
    chk("pre_rst_an", 32'(bus.an), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(bus.an), 0);
    chk("async_seg", 32'(bus.seg), 0);
    chk("async_pending", 32'(bus.pending), 0);
    k = 0;
    m_disp = '0;
    m_pend = '0;
    m_pv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(24);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller that drives N common-anode/cathode digits through one shared seven_segment_display_deco instance. It holds a double-buffered N-nibble display word and walks a digit index at a programmable slot rate. A blanking guard at the start of each slot suppresses ghosting. It sits between the register/front-panel logic and the display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
DIV, 1000, clock cycles per digit slot (DIV > BLANK_CYCLES)
BLANK_CYCLES, 8, cycles at slot start with all digit enables off (>= 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
value  in  4*N_DIGITS  new display word; nibble i (bits 4i+3:4i) drives digit i
load  in  1  single-cycle strobe; captures value into pending buffer
digit_en  in  N_DIGITS  per-digit enable mask, sampled live every cycle
seg  out  7  segment drive, seg[0]=a ... seg[6]=g, registered
an  out  N_DIGITS  one-hot digit enable, active-high, registered
frame_done  out  1  one-cycle pulse at end of each full scan frame
pending  out  1  high while a loaded word awaits frame-boundary transfer

Behaviour:
- Reset (async assert, sync release on clk): cnt=0, idx=0, disp=0, pend=0, pend_valid=0, seg=7'h00, an=0, frame_done=0.
- Slot counter cnt: width $clog2(DIV); increments every clk; at cnt==DIV-1 wraps to 0 and idx advances (idx N_DIGITS-1 wraps to 0).
- Phase: BLANK when cnt < BLANK_CYCLES, SHOW otherwise (state enum from package).
- Output registers (1-cycle lag): on each edge, an <= (SHOW && digit_en[idx]) ? (1 << idx) : 0; seg <= decoder(disp nibble idx). an and seg therefore reflect the pre-edge cnt/idx and always change together.
- Disabled digit (digit_en bit low): an stays 0 for its entire slot; slot timing unchanged (no skipping).
- Decoder is active-high standard hex: 0->7'h3F, 1->7'h06, 8->7'h7F, F->7'h71.
- Load: load=1 -> pend <= value, pend_valid <= 1. A second load before transfer overwrites pend (last write wins).
- Frame end (cnt==DIV-1 && idx==N_DIGITS-1): frame_done <= 1 for one cycle; if pend_valid or load: disp <= (load ? value : pend), pend_valid <= 0. A load coinciding with frame end goes straight to disp, and pending stays 0.
- disp never changes mid-frame, so no tearing.
- pending = pend_valid (registered).
- Reset mid-frame: all state clears immediately; an=0 asynchronously; scan restarts at digit 0, cnt 0.

Decomposition:
- Package seven_seg_pkg: typedef enum {PH_BLANK, PH_SHOW} scan_phase_t; SEG_BLANK=7'h00; glyph constants GLYPH_0..GLYPH_F for bench checking.
- One sub-module: seven_segment_display_deco, instantiated once, fed by the idx-selected nibble of disp; its s_a..s_g outputs are packed into seg[6:0] before the output register.

Test Plan (N_DIGITS=4, DIV=4, BLANK_CYCLES=1 unless noted):
- Reset then idle, digit_en=4'hF, no load -> an sequence per slot: 0,1,1,1 then 0,2,2,2, 0,4,4,4, 0,8,8,8; seg=7'h3F in SHOW; frame_done pulses every 16 cycles.
- load with value=16'h8F10 mid-frame -> pending=1 until frame end, then digits 0..3 show 7'h3F,7'h06,7'h71,7'h7F in the next frame; pending=0.
- Two loads (16'h1111 then 16'h2222) in one frame -> only 16'h2222 displayed next frame.
- load asserted exactly at the frame-end cycle with 16'h0008 -> digit 0 shows 7'h7F next frame; pending never rises.
- digit_en=4'b0101 -> an only ever 1 or 4; slot durations unchanged; frame_done period still 16.
- rst_n low mid-SHOW of digit 2 -> an=0 immediately, disp=0; after release scan restarts at digit 0 with a blank cycle.
